pc_seq: RTL and testbench
=========================

PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 Parameter RESET_VEC, default 11'h7FF: value loaded into the PC on reset.
REQ-002 clk  input  1  single rising-edge clock.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 step  input  1  instruction-cycle enable; state advances only on edges where step=1.
REQ-005 op  input  3  decoded operation: NEXT=0, GOTO=1, CALL=2, RETLW=3, SKIP=4, PCL_WR=5; codes 6-7 are reserved.
REQ-006 k  input  9  instruction literal.
REQ-007 pa  input  2  page-select bits (STATUS<6:5>).
REQ-008 pcl_data  input  8  data written to PCL when op=PCL_WR.
REQ-009 stack_out  input  11  top-of-stack return address from the two-level stack.
REQ-010 pc_out  output  11  fetch address; also drives the stack's PC_out input.
REQ-011 load_from_PC  output  1  stack push strobe: stack1<=pc_out.
REQ-012 load_from_stk1  output  1  stack push shift strobe: stack2<=stack1.
REQ-013 load_from_stk2  output  1  stack pop strobe: stack1<=stack2.
REQ-014 flush  output  1  the instruction now being fetched SHALL be executed as NOP.
REQ-015 depth  output  2  number of valid stack entries (0-2).
REQ-016 stk_ovf, stk_unf  output  1 each  sticky overflow and underflow flags.

Function
REQ-017 pc_out SHALL be a register; on each step=1 edge in state RUN it SHALL take one of the values below.
- NEXT: pc+1, wrapping 11'h7FF to 11'h000.
- GOTO: {pa,k[8:0]}.
- CALL: {pa,1'b0,k[7:0]}.
- RETLW: stack_out.
- PCL_WR: {pa,1'b0,pcl_data}.
- SKIP: pc+1, wrapping as for NEXT.
- Reserved codes: behave as NEXT.
REQ-018 The stack strobes SHALL be combinational from op, step and state, and SHALL only be asserted when step=1 and state=RUN.
- CALL: load_from_PC=1 and load_from_stk1=1, so the stack captures the current pc_out (the return address) on the same edge that the PC loads the target.
- RETLW: load_from_stk2=1, so the PC takes stack_out while the stack pops.
REQ-019 Push and pop strobes SHALL never be asserted in the same cycle.
REQ-020 The FSM SHALL have two states, RUN and FLUSH; GOTO, CALL, RETLW, PCL_WR and SKIP each move RUN->FLUSH on a step=1 edge.
REQ-021 In FLUSH: flush=1, op is ignored, the PC increments by one, no stack strobes are asserted, and the next step=1 edge returns the FSM to RUN.
REQ-022 When step=0, the PC, FSM, depth and flags SHALL hold their values and all strobes SHALL be 0.
REQ-023 Boundary behaviour of the PC and stack:
- PC wrap-around: 11'h7FF+1 = 11'h000, with no flag raised.
- The stack keeps stack2 unchanged on a pop, so a third consecutive RETLW returns the bottom entry again.

Reset
REQ-024 While rst_n=0, independent of clk, the outputs SHALL be:
- pc_out=RESET_VEC;
- state=RUN and flush=0;
- depth=0, stk_ovf=0, stk_unf=0;
- all strobes=0.
REQ-025 If reset is asserted during FLUSH, the pending flush SHALL be discarded; the stack contents are not reset by this block.

Configuration
REQ-026 Macro PC_SEQ_STK_CHECK_EN selects whether stack-depth checking is compiled in.
- Defined: depth tracking is present.
  - A CALL at depth<2 increments depth.
  - A CALL at depth=2 keeps depth=2 and sets stk_ovf.
  - A RETLW at depth>0 decrements depth.
  - A RETLW at depth=0 keeps depth=0 and sets stk_unf; pc_out still loads stack_out.
  - stk_ovf and stk_unf clear only on reset.
- Undefined: depth, stk_ovf and stk_unf are tied to 0 and the tracking logic is absent.

Structure
REQ-027 Shared package pic_pkg SHALL hold:
- PC_W=11;
- the op encoding typedef;
- the state typedef;
- the default RESET_VEC constant.
REQ-028 The depth counter and flag logic SHALL live in sub-module stk_depth, instantiated only when PC_SEQ_STK_CHECK_EN is defined.

Verification
REQ-029 Reset and fetch: release rst_n, then 3 NEXT steps -> pc_out is 7FF, 000, 001, 002; flush=0 throughout.
REQ-030 Call/return: pc=0x010, CALL k=0x1AB with pa=2'b01 -> on the same edge stack1 captures 0x010 and pc=0x2AB; flush=1 for one step. A later RETLW -> pc=0x010 and depth returns to 0.
REQ-031 Overflow: three nested CALLs -> depth=2 and stk_ovf=1 after the third. Three RETLWs -> the third returns the same address as the second, and stk_unf=1.
REQ-032 step gating: hold step=0 for 5 cycles with op=GOTO -> pc, flush and strobes remain unchanged or 0.
REQ-033 Reset mid-flush: GOTO k=0x055, then assert rst_n=0 during FLUSH -> pc=7FF and flush=0 immediately, with no clock edge required.
REQ-034 Macro build without PC_SEQ_STK_CHECK_EN: repeat the REQ-031 stimulus -> depth, stk_ovf and stk_unf remain 0, and the PC sequence is identical to the REQ-031 run.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared types and constants for the PIC-style program-counter sequencer.
package pic_pkg;

  localparam int PC_W = 11;
  localparam logic [PC_W-1:0] RESET_VEC_DEF = 11'h7FF;

  typedef enum logic [2:0] {
    OP_NEXT   = 3'd0,
    OP_GOTO   = 3'd1,
    OP_CALL   = 3'd2,
    OP_RETLW  = 3'd3,
    OP_SKIP   = 3'd4,
    OP_PCL_WR = 3'd5,
    OP_RSV6   = 3'd6,
    OP_RSV7   = 3'd7
  } op_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/stk_depth.sv
// Two-level stack occupancy counter with sticky overflow/underflow flags.
// Only instantiated by pc_seq when PC_SEQ_STK_CHECK_EN is defined.
module stk_depth
  import pic_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  output logic [1:0] depth,
  output logic       stk_ovf,
  output logic       stk_unf
);

  logic [1:0] depth_q, depth_d;
  logic       ovf_q, ovf_d;
  logic       unf_q, unf_d;

  always_comb begin
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (push) begin
      if (depth_q < 2'd2) depth_d = depth_q + 2'd1;
      else                ovf_d   = 1'b1;
    end else if (pop) begin
      if (depth_q != 2'd0) depth_d = depth_q - 2'd1;
      else                 unf_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_q <= 2'd0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign depth   = depth_q;
  assign stk_ovf = ovf_q;
  assign stk_unf = unf_q;

endmodule

// File: rtl/pc_seq.sv
// Program counter / fetch sequencer with RUN/FLUSH pipeline-refill FSM.
// Define PC_SEQ_STK_CHECK_EN to compile in stack depth tracking (stk_depth).
module pc_seq
  import pic_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VEC = RESET_VEC_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            step,
  input  logic [2:0]      op,
  input  logic [8:0]      k,
  input  logic [1:0]      pa,
  input  logic [7:0]      pcl_data,
  input  logic [PC_W-1:0] stack_out,
  output logic [PC_W-1:0] pc_out,
  output logic            load_from_PC,
  output logic            load_from_stk1,
  output logic            load_from_stk2,
  output logic            flush,
  output logic [1:0]      depth,
  output logic            stk_ovf,
  output logic            stk_unf
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            push, pop;
  op_e             op_dec;

  assign op_dec = op_e'(op);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    pop     = 1'b0;
    if (step) begin
      if (state_q == ST_FLUSH) begin
        // The fetched instruction is discarded; op is ignored.
        pc_d    = pc_q + 11'd1;
        state_d = ST_RUN;
      end else begin
        unique case (op_dec)
          OP_GOTO: begin
            pc_d    = {pa, k};
            state_d = ST_FLUSH;
          end
          OP_CALL: begin
            pc_d    = {pa, 1'b0, k[7:0]};
            push    = 1'b1;
            state_d = ST_FLUSH;
          end
          OP_RETLW: begin
            pc_d    = stack_out;
            pop     = 1'b1;
            state_d = ST_FLUSH;
          end
          OP_PCL_WR: begin
            pc_d    = {pa, 1'b0, pcl_data};
            state_d = ST_FLUSH;
          end
          OP_SKIP: begin
            pc_d    = pc_q + 11'd1;
            state_d = ST_FLUSH;
          end
          default: pc_d = pc_q + 11'd1;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_VEC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign pc_out         = pc_q;
  assign flush          = (state_q == ST_FLUSH);
  assign load_from_PC   = push;
  assign load_from_stk1 = push;
  assign load_from_stk2 = pop;

`ifdef PC_SEQ_STK_CHECK_EN
  stk_depth u_stk_depth (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .depth   (depth),
    .stk_ovf (stk_ovf),
    .stk_unf (stk_unf)
  );
`else
  assign depth   = 2'd0;
  assign stk_ovf = 1'b0;
  assign stk_unf = 1'b0;
`endif

endmodule

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model with its own stack copy.
module tb_pc_seq;
  import pic_pkg::*;

`ifdef PC_SEQ_STK_CHECK_EN
  localparam bit STK_EN = 1'b1;
`else
  localparam bit STK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        step = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [8:0]  k = 9'd0;
  logic [1:0]  pa = 2'd0;
  logic [7:0]  pcl_data = 8'd0;
  logic [10:0] stack_out;
  logic [10:0] pc_out;
  logic        load_from_PC, load_from_stk1, load_from_stk2, flush;
  logic [1:0]  depth;
  logic        stk_ovf, stk_unf;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  pc_seq dut (
    .clk(clk), .rst_n(rst_n), .step(step), .op(op), .k(k), .pa(pa),
    .pcl_data(pcl_data), .stack_out(stack_out), .pc_out(pc_out),
    .load_from_PC(load_from_PC), .load_from_stk1(load_from_stk1),
    .load_from_stk2(load_from_stk2), .flush(flush), .depth(depth),
    .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  always #5 clk = ~clk;

  // External two-level stack, driven by the DUT strobes.
  logic [10:0] e_s1 = 11'd0, e_s2 = 11'd0;
  always @(posedge clk) begin
    if (load_from_PC)   e_s1 <= pc_out;
    if (load_from_stk1) e_s2 <= e_s1;
    if (load_from_stk2) e_s1 <= e_s2;
  end
  assign stack_out = e_s1;

  // Behavioural model: PC value, "next fetch is discarded" bit, stack copy.
  logic [10:0] m_pc = 11'h7FF;
  bit          m_fl = 1'b0;
  int          m_depth = 0;
  bit          m_ovf = 1'b0, m_unf = 1'b0;
  logic [10:0] m_s1 = 11'd0, m_s2 = 11'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= 11'h7FF; m_fl <= 1'b0; m_depth <= 0; m_ovf <= 1'b0; m_unf <= 1'b0;
    end else if (step) begin
      if (m_fl) begin
        m_pc <= m_pc + 11'd1;
        m_fl <= 1'b0;
      end else begin
        m_fl <= (op >= 3'd1 && op <= 3'd5);
        case (op)
          3'd1: m_pc <= {pa, k};
          3'd2: begin
            m_pc <= {pa, 1'b0, k[7:0]};
            m_s1 <= m_pc;
            m_s2 <= m_s1;
            if (STK_EN) begin
              if (m_depth < 2) m_depth <= m_depth + 1; else m_ovf <= 1'b1;
            end
          end
          3'd3: begin
            m_pc <= m_s1;
            m_s1 <= m_s2;
            if (STK_EN) begin
              if (m_depth > 0) m_depth <= m_depth - 1; else m_unf <= 1'b1;
            end
          end
          3'd5: m_pc <= {pa, 1'b0, pcl_data};
          default: m_pc <= m_pc + 11'd1;
        endcase
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on && rst_n) begin
      chk("pc", 32'(pc_out), 32'(m_pc));
      chk("flush", 32'(flush), 32'(m_fl));
      chk("depth", 32'(depth), 32'(m_depth));
      chk("stk_ovf", 32'(stk_ovf), 32'(m_ovf));
      chk("stk_unf", 32'(stk_unf), 32'(m_unf));
      chk("ld_pc", 32'(load_from_PC), 32'(step && !m_fl && op == 3'd2));
      chk("ld_stk1", 32'(load_from_stk1), 32'(step && !m_fl && op == 3'd2));
      chk("ld_stk2", 32'(load_from_stk2), 32'(step && !m_fl && op == 3'd3));
    end
  end

  task automatic step_op(input logic [2:0] o, input logic [8:0] kk,
                         input logic [1:0] p, input logic [7:0] d);
    step = 1'b1; op = o; k = kk; pa = p; pcl_data = d;
    @(posedge clk);
    #2;
  endtask

  task automatic pcf(input string name, input logic [10:0] epc, input logic efl);
    chk({name, "_pc"}, 32'(pc_out), 32'(epc));
    chk({name, "_flush"}, 32'(flush), 32'(efl));
  endtask

  logic [10:0] pc_hold;

  initial begin
    // Reset and fetch
    repeat (2) @(posedge clk);
    #2;
    pcf("rst", 11'h7FF, 1'b0);
    chk("rst_strobes", 32'({load_from_PC, load_from_stk1, load_from_stk2}), 32'd0);
    rst_n = 1'b1;
    chk_on = 1'b1;
    #1 pcf("rel", 11'h7FF, 1'b0);
    step_op(3'd0, 9'd0, 2'd0, 8'd0); pcf("fetch0", 11'h000, 1'b0);
    step_op(3'd0, 9'd0, 2'd0, 8'd0); pcf("fetch1", 11'h001, 1'b0);
    step_op(3'd0, 9'd0, 2'd0, 8'd0); pcf("fetch2", 11'h002, 1'b0);

    // Call / return
    step_op(3'd1, 9'h00F, 2'd0, 8'd0); pcf("goto", 11'h00F, 1'b1);
    step_op(3'd0, 9'd0, 2'd0, 8'd0);   pcf("goto_fl", 11'h010, 1'b0);
    step = 1'b1; op = 3'd2; k = 9'h1AB; pa = 2'b01;
    #1 chk("call_strobes", 32'({load_from_PC, load_from_stk1, load_from_stk2}), 32'b110);
    @(posedge clk); #2;
    pcf("call", 11'h2AB, 1'b1);
    chk("call_stack1", 32'(e_s1), 32'h010);
    chk("call_depth", 32'(depth), STK_EN ? 32'd1 : 32'd0);
    step_op(3'd0, 9'd0, 2'd0, 8'd0); pcf("call_fl", 11'h2AC, 1'b0);
    step_op(3'd3, 9'd0, 2'd0, 8'd0); pcf("ret", 11'h010, 1'b1);
    chk("ret_depth", 32'(depth), 32'd0);
    step_op(3'd0, 9'd0, 2'd0, 8'd0); pcf("ret_fl", 11'h011, 1'b0);

    // Nested calls: overflow, then underflow
    step_op(3'd2, 9'h020, 2'd0, 8'd0); step_op(3'd0, 9'd0, 2'd0, 8'd0);
    pcf("c1", 11'h021, 1'b0);
    step_op(3'd2, 9'h040, 2'd0, 8'd0); step_op(3'd0, 9'd0, 2'd0, 8'd0);
    pcf("c2", 11'h041, 1'b0);
    chk("c2_ovf", 32'(stk_ovf), 32'd0);
    step_op(3'd2, 9'h060, 2'd0, 8'd0);
    pcf("c3", 11'h060, 1'b1);
    chk("c3_depth", 32'(depth), STK_EN ? 32'd2 : 32'd0);
    chk("c3_ovf", 32'(stk_ovf), STK_EN ? 32'd1 : 32'd0);
    step_op(3'd0, 9'd0, 2'd0, 8'd0);
    step_op(3'd3, 9'd0, 2'd0, 8'd0); pcf("r1", 11'h041, 1'b1);
    step_op(3'd0, 9'd0, 2'd0, 8'd0);
    step_op(3'd3, 9'd0, 2'd0, 8'd0); pcf("r2", 11'h021, 1'b1);
    chk("r2_unf", 32'(stk_unf), 32'd0);
    step_op(3'd0, 9'd0, 2'd0, 8'd0);
    step_op(3'd3, 9'd0, 2'd0, 8'd0); pcf("r3", 11'h021, 1'b1);
    chk("r3_depth", 32'(depth), 32'd0);
    chk("r3_unf", 32'(stk_unf), STK_EN ? 32'd1 : 32'd0);
    step_op(3'd0, 9'd0, 2'd0, 8'd0); pcf("r3_fl", 11'h022, 1'b0);

    // step gating
    step = 1'b0; op = 3'd1; k = 9'h1FF; pa = 2'b11;
    repeat (5) begin
      @(posedge clk); #2;
      pcf("hold", 11'h022, 1'b0);
      chk("hold_strobes", 32'({load_from_PC, load_from_stk1, load_from_stk2}), 32'd0);
    end
    op = 3'd2;
    #1 chk("hold_call_strobes", 32'({load_from_PC, load_from_stk1, load_from_stk2}), 32'd0);

    // Wrap-around through PCL write to 0x7FF
    step_op(3'd5, 9'd0, 2'b11, 8'hFF); pcf("pclwr", 11'h6FF, 1'b1);
    step_op(3'd1, 9'h1FF, 2'b11, 8'd0); pcf("fl_ignores_op", 11'h700, 1'b0);
    step_op(3'd1, 9'h1FF, 2'b11, 8'd0); pcf("goto7ff", 11'h7FF, 1'b1);
    step_op(3'd0, 9'd0, 2'd0, 8'd0); pcf("wrap", 11'h000, 1'b0);

    // Reset mid-flush
    step_op(3'd1, 9'h055, 2'd0, 8'd0); pcf("goto55", 11'h055, 1'b1);
    step = 1'b0;
    rst_n = 1'b0;
    #1 pcf("async_rst", 11'h7FF, 1'b0);
    chk("async_rst_ovf", 32'({stk_ovf, stk_unf, depth}), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1 pcf("rst_rel2", 11'h7FF, 1'b0);

    // Randomized traffic, checked by the per-cycle compare process
    for (int i = 0; i < 600; i++) begin
      step = ($urandom_range(0, 9) < 7);
      op = 3'($urandom_range(0, 7));
      k = 9'($urandom);
      pa = 2'($urandom);
      pcl_data = 8'($urandom);
      @(posedge clk); #2;
    end
    step = 1'b0;
    @(negedge clk);
    pc_hold = pc_out;
    @(posedge clk); #2;
    chk("final_hold", 32'(pc_out), 32'(pc_hold));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
